// File: rtl/bsg_round_robin_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bsg_round_robin_arb
// Purpose  : Two-input round-robin arbiter. The grant is combinational and
//            the last-winner pointer advances whenever a grant is issued.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module bsg_round_robin_arb (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       grants_en_i,
  input  logic [1:0] reqs_i,
  output logic [1:0] grants_o,
  output logic       v_o,
  output logic       tag_o
);

  logic last_q;

  // Pick the winner: a lone requester always wins; on contention the
  // requester that did not win last time gets the grant.
  always_comb begin
    tag_o = 1'b0;
    unique case (reqs_i)
      2'b01:   tag_o = 1'b0;
      2'b10:   tag_o = 1'b1;
      2'b11:   tag_o = ~last_q;
      default: tag_o = 1'b0;
    endcase
    v_o      = grants_en_i & (|reqs_i);
    grants_o = v_o ? (tag_o ? 2'b10 : 2'b01) : 2'b00;
  end

  // Remember the most recent winner; reset value 1 makes requester 0 win
  // the first contention.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q <= 1'b1;
    end else if (v_o) begin
      last_q <= tag_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_mem_1rw_mask_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bsg_mem_1rw_mask_arb
// Purpose  : Shares one single-port masked-write SRAM between two requesters.
//            Optionally zero-fills the SRAM after reset, then arbitrates
//            requests round-robin and returns read data one cycle later.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module bsg_mem_1rw_mask_arb #(
  parameter int width_p       = -1,
  parameter int els_p         = -1,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int init_zero_p   = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [1:0]                 r_v_i,
  input  logic [1:0]                 r_w_i,
  input  logic [2*addr_width_lp-1:0] r_addr_i,
  input  logic [2*width_p-1:0]       r_data_i,
  input  logic [2*width_p-1:0]       r_w_mask_i,
  output logic [1:0]                 r_yumi_o,
  output logic [1:0]                 r_v_o,
  output logic [width_p-1:0]         r_data_o,
  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [addr_width_lp-1:0]   mem_addr_o,
  output logic [width_p-1:0]         mem_data_o,
  output logic [width_p-1:0]         mem_w_mask_o,
  input  logic [width_p-1:0]         mem_data_i,
  output logic                       init_done_o
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                   state_q;
  logic [addr_width_lp-1:0] cnt_q;
  logic                     init_done_q;
  logic                     rd_v_q, rd_v_d;
  logic                     rd_id_q, rd_id_d;

  logic                     arb_v;
  logic                     arb_tag;
  logic [1:0]               arb_grants;
  logic                     grants_en;

  // Requests are only served in RUN and never while reset is held.
  assign grants_en = (state_q == RUN) & ~reset_i;

  bsg_round_robin_arb u_arb (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .grants_en_i (grants_en),
    .reqs_i      (r_v_i),
    .grants_o    (arb_grants),
    .v_o         (arb_v),
    .tag_o       (arb_tag)
  );

  assign r_yumi_o    = arb_grants;
  assign init_done_o = init_done_q;

  // Drive the SRAM port: zero-fill writes in INIT, the winner's request in RUN.
  always_comb begin
    mem_v_o      = 1'b0;
    mem_w_o      = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    mem_w_mask_o = '0;
    if (reset_i) begin
      mem_v_o = 1'b0;
    end else if (state_q == INIT) begin
      mem_v_o      = 1'b1;
      mem_w_o      = 1'b1;
      mem_addr_o   = cnt_q;
      mem_w_mask_o = '1;
    end else if (arb_v) begin
      mem_v_o      = 1'b1;
      mem_w_o      = arb_tag ? r_w_i[1] : r_w_i[0];
      mem_addr_o   = arb_tag ? r_addr_i[2*addr_width_lp-1:addr_width_lp]
                             : r_addr_i[addr_width_lp-1:0];
      mem_data_o   = arb_tag ? r_data_i[2*width_p-1:width_p]
                             : r_data_i[width_p-1:0];
      mem_w_mask_o = arb_tag ? r_w_mask_i[2*width_p-1:width_p]
                             : r_w_mask_i[width_p-1:0];
    end
  end

  // Only granted reads produce a response; remember who asked.
  always_comb begin
    rd_v_d  = arb_v & ~mem_w_o;
    rd_id_d = arb_tag;
  end

  // INIT/RUN state machine with the zero-fill address counter.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= (init_zero_p != 0) ? INIT : RUN;
      init_done_q <= (init_zero_p == 0);
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        INIT: begin
          if (cnt_q == addr_width_lp'(els_p - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
            cnt_q       <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
      endcase
    end
  end

  // Register the read-valid and requester id for the response cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_v_q  <= 1'b0;
      rd_id_q <= 1'b0;
    end else begin
      rd_v_q  <= rd_v_d;
      rd_id_q <= rd_id_d;
    end
  end

  assign r_v_o    = rd_v_q ? (rd_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign r_data_o = mem_data_i;

`ifndef SYNTHESIS
  a_addr_range : assert property (@(posedge clk_i) disable iff (reset_i)
    (r_yumi_o != 2'b00) |-> (int'(mem_addr_o) < els_p))
    else $error("granted address out of range");

  a_v_known : assert property (@(posedge clk_i) disable iff (reset_i)
    !$isunknown(r_v_i))
    else $error("r_v_i is unknown");
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_mem_1rw_mask_arb.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_bsg_mem_1rw_mask_arb
// Purpose  : Directed bench for the two-requester masked SRAM arbiter, with
//            a zero-filling instance and a no-init instance, each backed by
//            a behavioural masked-write SRAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bsg_mem_1rw_mask_arb;

  localparam int W  = 8;
  localparam int N  = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: zero-fill enabled ----------------
  logic            rst_a;
  logic [1:0]      a_v, a_w, a_yumi, a_rv;
  logic [2*AW-1:0] a_addr;
  logic [2*W-1:0]  a_data, a_mask;
  logic [W-1:0]    a_rdata, a_mdata, a_mmask, a_rd;
  logic            a_mv, a_mw, a_done;
  logic [AW-1:0]   a_maddr;
  logic [W-1:0]    mem_a [N];

  bsg_mem_1rw_mask_arb #(.width_p(W), .els_p(N), .init_zero_p(1)) dut_a (
    .clk_i(clk), .reset_i(rst_a),
    .r_v_i(a_v), .r_w_i(a_w), .r_addr_i(a_addr), .r_data_i(a_data), .r_w_mask_i(a_mask),
    .r_yumi_o(a_yumi), .r_v_o(a_rv), .r_data_o(a_rdata),
    .mem_v_o(a_mv), .mem_w_o(a_mw), .mem_addr_o(a_maddr), .mem_data_o(a_mdata),
    .mem_w_mask_o(a_mmask), .mem_data_i(a_rd), .init_done_o(a_done)
  );

  always @(posedge clk) begin
    if (a_mv) begin
      if (a_mw) mem_a[a_maddr] <= (mem_a[a_maddr] & ~a_mmask) | (a_mdata & a_mmask);
      else      a_rd <= mem_a[a_maddr];
    end
  end

  // ---------------- instance B: no zero-fill ----------------
  logic            rst_b;
  logic [1:0]      b_v, b_w, b_yumi, b_rv;
  logic [2*AW-1:0] b_addr;
  logic [2*W-1:0]  b_data, b_mask;
  logic [W-1:0]    b_rdata, b_mdata, b_mmask, b_rd;
  logic            b_mv, b_mw, b_done;
  logic [AW-1:0]   b_maddr;
  logic [W-1:0]    mem_b [N];

  bsg_mem_1rw_mask_arb #(.width_p(W), .els_p(N), .init_zero_p(0)) dut_b (
    .clk_i(clk), .reset_i(rst_b),
    .r_v_i(b_v), .r_w_i(b_w), .r_addr_i(b_addr), .r_data_i(b_data), .r_w_mask_i(b_mask),
    .r_yumi_o(b_yumi), .r_v_o(b_rv), .r_data_o(b_rdata),
    .mem_v_o(b_mv), .mem_w_o(b_mw), .mem_addr_o(b_maddr), .mem_data_o(b_mdata),
    .mem_w_mask_o(b_mmask), .mem_data_i(b_rd), .init_done_o(b_done)
  );

  always @(posedge clk) begin
    if (b_mv) begin
      if (b_mw) mem_b[b_maddr] <= (mem_b[b_maddr] & ~b_mmask) | (b_mdata & b_mmask);
      else      b_rd <= mem_b[b_maddr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      mem_a[i] = 8'hA5;
      mem_b[i] = W'(i * 8'h11);
    end
    a_rd = '0; b_rd = '0;
    rst_a = 1'b1; rst_b = 1'b1;
    a_v = 2'b11; a_w = 2'b00; a_addr = '0; a_data = '0; a_mask = '0;
    b_v = 2'b11; b_w = 2'b00; b_addr = '0; b_data = '0; b_mask = '0;

    repeat (3) tick();
    chk("a_reset", 64'({a_yumi, a_rv, a_mv, a_done}), 64'(6'b000000));
    chk("b_reset", 64'({b_yumi, b_rv, b_mv, b_done}), 64'(6'b000001));

    // zero-fill, interrupted by reset at address 7
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("init_pre", 64'({a_mv, a_mw, a_maddr, a_mdata, a_mmask, a_yumi, a_done}),
          64'({1'b1, 1'b1, 4'(i), 8'h00, 8'hFF, 2'b00, 1'b0}));
      if (i < 7) tick();
    end
    rst_a = 1'b1;
    #1;
    chk("init_abort", 64'({a_mv, a_yumi, a_done}), 64'(4'b0000));
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < N; i++) begin
      #1;
      chk("init_full", 64'({a_mv, a_mw, a_maddr, a_mdata, a_mmask, a_yumi, a_done}),
          64'({1'b1, 1'b1, 4'(i), 8'h00, 8'hFF, 2'b00, 1'b0}));
      tick();
    end
    a_v = 2'b00;
    #1;
    chk("init_done", 64'({a_done, a_mv, a_yumi}), 64'(4'b1000));
    chk("zero_mem7", 64'(mem_a[7]), 64'(8'h00));

    // preload writes from each requester alone
    a_v = 2'b01; a_w = 2'b01; a_addr = {4'd0, 4'd2}; a_data = {8'h00, 8'h3C}; a_mask = {8'h00, 8'hFF};
    #1;
    chk("wr0_grant", 64'({a_yumi, a_mv, a_mw, a_maddr, a_mdata, a_mmask}),
        64'({2'b01, 1'b1, 1'b1, 4'd2, 8'h3C, 8'hFF}));
    tick();
    a_v = 2'b10; a_w = 2'b10; a_addr = {4'd5, 4'd0}; a_data = {8'hC3, 8'h00}; a_mask = {8'hFF, 8'h00};
    #1;
    chk("wr1_grant", 64'({a_yumi, a_mv, a_mw, a_maddr, a_mdata, a_mmask}),
        64'({2'b10, 1'b1, 1'b1, 4'd5, 8'hC3, 8'hFF}));
    chk("wr_no_resp", 64'(a_rv), 64'(2'b00));
    tick();

    // masked write then read by the other requester
    a_v = 2'b01; a_w = 2'b01; a_addr = {4'd0, 4'd3}; a_data = {8'h00, 8'hFF}; a_mask = {8'h00, 8'h0F};
    #1;
    chk("mwr_grant", 64'({a_yumi, a_maddr, a_mmask}), 64'({2'b01, 4'd3, 8'h0F}));
    tick();
    a_v = 2'b10; a_w = 2'b00; a_addr = {4'd3, 4'd0}; a_data = '0; a_mask = '0;
    #1;
    chk("rd1_grant", 64'({a_yumi, a_mv, a_mw, a_maddr, a_rv}), 64'({2'b10, 1'b1, 1'b0, 4'd3, 2'b00}));
    tick();
    a_v = 2'b00;
    #1;
    chk("rd1_resp", 64'({a_rv, a_rdata, a_mv}), 64'({2'b10, 8'h0F, 1'b0}));
    tick();

    // contention: both read continuously, grants alternate starting at 0
    a_v = 2'b11; a_w = 2'b00; a_addr = {4'd5, 4'd2};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("cont_grant", 64'({a_yumi, a_maddr}), (k % 2 == 0) ? 64'({2'b01, 4'd2}) : 64'({2'b10, 4'd5}));
      if (k == 0)
        chk("cont_resp0", 64'(a_rv), 64'(2'b00));
      else
        chk("cont_resp", 64'({a_rv, a_rdata}),
            (k % 2 == 1) ? 64'({2'b01, 8'h3C}) : 64'({2'b10, 8'hC3}));
      tick();
    end
    a_v = 2'b00;
    #1;
    chk("cont_last", 64'({a_rv, a_rdata}), 64'({2'b10, 8'hC3}));
    tick();
    #1;
    chk("cont_idle", 64'(a_rv), 64'(2'b00));

    // reset with a read response pending
    a_v = 2'b01; a_w = 2'b00; a_addr = {4'd0, 4'd2};
    tick();
    rst_a = 1'b1; a_v = 2'b00;
    #1;
    chk("rst_drop", 64'({a_rv, a_mv, a_yumi}), 64'(5'b00000));
    tick();
    rst_a = 1'b0;
    #1;
    chk("rst_restart", 64'({a_mv, a_maddr, a_done}), 64'({1'b1, 4'd0, 1'b0}));

    // instance B: no zero-fill, requester 1 alone is served every cycle
    rst_b = 1'b0;
    b_v = 2'b11; b_addr = {4'd4, 4'd1};
    #1;
    chk("b_done", 64'(b_done), 64'(1'b1));
    chk("b_first_cont", 64'({b_yumi, b_maddr}), 64'({2'b01, 4'd1}));
    tick();
    b_v = 2'b10;
    for (int k = 0; k < 5; k++) begin
      b_addr = {4'(4 + k), 4'd0};
      #1;
      chk("b_grant", 64'({b_yumi, b_maddr, b_done}), 64'({2'b10, 4'(4 + k), 1'b1}));
      if (k == 0)
        chk("b_resp0", 64'({b_rv, b_rdata}), 64'({2'b01, 8'h11}));
      else
        chk("b_resp", 64'({b_rv, b_rdata}), 64'({2'b10, 8'(8'h11 * (3 + k))}));
      tick();
    end
    b_v = 2'b00;
    #1;
    chk("b_last", 64'({b_rv, b_rdata}), 64'({2'b10, 8'h88}));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bsg_mem_1rw_mask_arb.md
BSG_MEM_1RW_MASK_ARB -- requirements
Module: bsg_mem_1rw_mask_arb

Interface
REQ-001 Parameters SHALL be: width_p, default -1, data width in bits; els_p, default -1, number of entries; addr_width_lp, default `BSG_SAFE_CLOG2(els_p), address width; init_zero_p, default 1, zero-fill the memory after reset.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high. Port clk_i, input, 1 bit, clock.
REQ-003 Port reset_i, input, 1 bit, asynchronous active-high reset.
REQ-004 Port r_v_i, input, 2 bits, per-requester request valid.
REQ-005 Port r_w_i, input, 2 bits, per-requester write (1) or read (0).
REQ-006 Port r_addr_i, input, 2 x addr_width_lp bits, per-requester address.
REQ-007 Port r_data_i, input, 2 x width_p bits, per-requester write data.
REQ-008 Port r_w_mask_i, input, 2 x width_p bits, per-requester bit write mask.
REQ-009 Port r_yumi_o, output, 2 bits, request accepted this cycle.
REQ-010 Port r_v_o, output, 2 bits, read data valid.
REQ-011 Port r_data_o, output, width_p bits, read data, shared by both requesters and qualified by r_v_o.
REQ-012 Ports mem_v_o, mem_w_o (1 bit each), mem_addr_o (addr_width_lp bits) and mem_data_o, mem_w_mask_o (width_p bits each) SHALL be outputs driving the single-port masked SRAM.
REQ-013 Port mem_data_i, input, width_p bits, SRAM read data, valid one cycle after a read.
REQ-014 Port init_done_o, output, 1 bit, zero-fill complete and requests are served.

Function
REQ-015 The FSM SHALL have two states, INIT and RUN. Reset SHALL enter INIT when init_zero_p=1 and RUN otherwise.
REQ-016 In INIT the block SHALL issue one SRAM write per cycle: mem_v_o=1, mem_w_o=1, data 0, mask all ones, address counting 0 to els_p-1.
REQ-017 In INIT, r_yumi_o SHALL be 0 and init_done_o SHALL be 0.
REQ-018 The cycle after the write to address els_p-1, the FSM SHALL move to RUN. It SHALL stay in RUN until reset. INIT therefore lasts exactly els_p cycles.
REQ-019 In RUN, init_done_o SHALL be 1.
REQ-020 In RUN, at most one requester SHALL be granted per cycle, and a grant SHALL occur whenever any r_v_i bit is 1.
REQ-021 If exactly one requester is valid, that requester SHALL be granted.
REQ-022 If both requesters are valid, the requester that did not win the most recent grant SHALL be granted (round-robin). The last-winner pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-023 A grant SHALL be combinational in the same cycle: r_yumi_o[g]=1, and mem_v_o/mem_w_o/mem_addr_o/mem_data_o/mem_w_mask_o SHALL equal requester g's inputs.
REQ-024 r_yumi_o SHALL depend on r_v_i. A requester SHALL hold its request stable until it sees yumi.
REQ-025 With no grant, mem_v_o SHALL be 0, and the other mem outputs SHALL be don't-care (driven as 0).
REQ-026 A granted read SHALL assert r_v_o[g] for exactly one cycle, the cycle after the grant, with r_data_o=mem_data_i. There SHALL be no response backpressure.
REQ-027 A granted write SHALL produce no response.
REQ-028 Back-to-back reads by alternating requesters SHALL give one response per cycle with no bubble. r_v_o SHALL be one-hot or zero.
REQ-029 If the read returned in a cycle is not the most recent grant, r_v_o SHALL reflect only the grant registered in the previous cycle.

Reset
REQ-030 Reset SHALL set: state = INIT or RUN per init_zero_p, init counter = 0, last-winner = 1, and the registered read-valid/grant-id = 0.
REQ-031 Output reset values SHALL be: r_yumi_o=0, r_v_o=0, init_done_o=0 (1 if init_zero_p=0), mem_v_o=0 when reset_i=1.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL abort all activity. On release, zero-fill SHALL restart from address 0. Any pending read response SHALL be dropped.
REQ-033 Simulation-only assertions SHALL flag a granted address >= els_p and X on r_v_i after reset.

Structure
REQ-034 No shared package SHALL be required. The FSM state enum SHALL be local to the module.
REQ-035 The module SHALL instantiate one sub-module: bsg_round_robin_arb (2 inputs) for the grant.
REQ-036 The SRAM itself (bsg_mem_1rw_sync_mask_write_bit) SHALL be instantiated by the parent, not inside this block.

Verification
REQ-037 Zero-fill: els_p=16, init_zero_p=1, release reset -> 16 consecutive writes to addresses 0..15 with data 0 and mask all ones; init_done_o rises in cycle 16; r_yumi_o=0 throughout.
REQ-038 Contention: both requesters read continuously in RUN -> grants alternate 0,1,0,1…; r_v_o alternates one cycle later with the correct data.
REQ-039 Masked write then read: req0 writes 0xFF to addr 3 with mask 0x0F, then req1 reads addr 3 -> r_v_o[1]=1 the next cycle with r_data_o=0x0F (memory zeroed, width_p=8).
REQ-040 Mid-INIT reset: assert reset at init address 7 -> on release, the counter restarts at 0 and init_done_o stays 0 for another els_p cycles.
REQ-041 Single requester with init_zero_p=0: req1 is the only valid requester -> granted every cycle, no starvation, init_done_o=1 from reset release.
